gb_cart_bus_seq: RTL and testbench
==================================

Name: gb_cart_bus_seq

Overview:
- Physical cartridge bus sequencer, directly downstream of the camera mapper's CPU-side register interface.
- Accepts one single-beat read/write request: 16-bit address, 8-bit write data.
- Runs a timed cycle on the cart port pins: PHI, /RD, /WR, /CS, A[15:0], D[7:0] with direction control.
- Returns captured read data to the mapper as a one-cycle response pulse.

Parameters:
- T_SETUP, 4, clk_sys cycles of address/data setup before PHI rises (>=1)
- T_STROBE, 16, clk_sys cycles PHI high / strobe active (>=2)
- T_HOLD, 4, clk_sys cycles of address/data hold after strobe ends (>=1)

Ports:
- clk_sys  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present; held stable until accepted
- req_ready  out  1  sequencer can accept; high only in IDLE
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  16  CPU address {a15, addr[14:0]}
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse at end of every cycle, read or write
- rsp_rdata  out  8  captured read data; 8'h00 for writes
- cart_phi  out  1  cartridge PHI clock
- cart_rd_n  out  1  read strobe, active low
- cart_wr_n  out  1  write strobe, active low
- cart_cs_n  out  1  SRAM/camera chip select, active low
- cart_a  out  16  cartridge address pins
- cart_dq_out  out  8  data to pins
- cart_dq_in  in  8  data from pins
- cart_dq_dir  out  1  1 = FPGA drives D[7:0]

Behaviour:
- Reset (async assert, sync release), all outputs:
  - req_ready=1, rsp_valid=0, rsp_rdata=0
  - cart_phi=0, cart_rd_n=1, cart_wr_n=1, cart_cs_n=1
  - cart_a=16'h0000, cart_dq_out=0, cart_dq_dir=0
- Reset assertion mid-cycle immediately forces pins to the reset values; the interrupted cycle produces no response.
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE.
- One down-counter, width $clog2(max(T_SETUP,T_STROBE,T_HOLD)+1); loaded on each state entry with T_x-1; transition taken when count==0.
- IDLE:
  - req_ready=1.
  - On req_valid: latch wr, addr, wdata into internal registers; enter SETUP.
  - Request inputs are not sampled again until the next IDLE.
- SETUP (T_SETUP cycles):
  - cart_a = latched addr.
  - Read: cart_rd_n=0.
  - Write: cart_dq_out = wdata, cart_dq_dir=1.
  - cart_phi=0.
- STROBE (T_STROBE cycles):
  - cart_phi=1.
  - cart_cs_n=0 iff addr[15:13]==3'b101 (A000-BFFF), else 1.
  - Write: cart_wr_n=0. Read: cart_rd_n stays 0.
  - Read data: on the last STROBE cycle (count==0), register cart_dq_in into the rdata latch.
- HOLD (T_HOLD cycles):
  - cart_phi=0, cart_wr_n=1, cart_cs_n=1.
  - cart_a held; write data still driven (dq_dir=1); cart_rd_n stays 0 for reads.
- DONE (1 cycle):
  - rsp_valid=1; rsp_rdata = latched data for reads, 8'h00 for writes.
  - All strobes deasserted, dq_dir=0, cart_a keeps the last address.
  - Next state IDLE.
- rsp_rdata holds its value until the next DONE.
- Cycle length: total latency from acceptance to rsp_valid = T_SETUP+T_STROBE+T_HOLD+1 cycles; next acceptance no earlier than 1 cycle after DONE.
- Glitch rules: all pin outputs registered; /WR never low while cart_dq_dir=0; /RD and /WR never low simultaneously.
- A req_valid arriving while busy is ignored (req_ready=0); the requester holds it.

Test Plan:
- Read 16'h4123, cart_dq_in=8'h5A at end of STROBE -> cart_rd_n low 24 cycles, cart_cs_n stays 1, rsp_valid at cycle 25 after accept, rsp_rdata=8'h5A.
- Write 16'h2000, data 8'h03 -> cart_wr_n low exactly 16 cycles, aligned to cart_phi high; cart_dq_dir high 24 cycles covering it; rsp_rdata=8'h00.
- Read 16'hA010 -> cart_cs_n low exactly during 16 PHI-high cycles; cart_dq_in changes after the STROBE sample point do not alter rsp_rdata.
- Back-to-back requests with req_valid held high -> second accepted exactly 1 cycle after first rsp_valid; req_ready=0 throughout the first cycle.
- reset_n pulsed low mid-STROBE of a write -> same-cycle pins return idle (wr_n=1, dq_dir=0, phi=0); no rsp_valid; next request completes normally.
- Parameter override T_SETUP=1, T_STROBE=2, T_HOLD=1 -> read latency 5 cycles; correct data captured.

Source files
------------

// File: rtl/gb_cart_bus_seq_if.sv
// Purpose : request/response and cartridge-pin bundle for the cart bus sequencer.
// Latency : none; this file only groups signals.
// Backpressure: req_valid is held by the master until req_ready is seen high.
//
// Signals:
//   req_valid/req_ready/req_wr/req_addr/req_wdata : single-beat request from the mapper
//   rsp_valid/rsp_rdata                           : one-cycle response pulse with read data
//   cart_phi/cart_rd_n/cart_wr_n/cart_cs_n        : cartridge control pins
//   cart_a, cart_dq_out, cart_dq_in, cart_dq_dir  : address pins, data pins and direction
//
// The master modport is the environment around the sequencer: it issues requests
// and also plays the cartridge, so it supplies cart_dq_in.
interface gb_cart_bus_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        cart_phi;
    logic        cart_rd_n;
    logic        cart_wr_n;
    logic        cart_cs_n;
    logic [15:0] cart_a;
    logic [7:0]  cart_dq_out;
    logic [7:0]  cart_dq_in;
    logic        cart_dq_dir;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, cart_dq_in,
        input  req_ready, rsp_valid, rsp_rdata,
        input  cart_phi, cart_rd_n, cart_wr_n, cart_cs_n, cart_a, cart_dq_out, cart_dq_dir
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, cart_dq_in,
        output req_ready, rsp_valid, rsp_rdata,
        output cart_phi, cart_rd_n, cart_wr_n, cart_cs_n, cart_a, cart_dq_out, cart_dq_dir
    );
endinterface

// File: rtl/gb_cart_bus_seq.sv
// Purpose : runs one timed read/write cycle on the Game Boy cartridge pins per request.
// Latency : rsp_valid T_SETUP+T_STROBE+T_HOLD+1 cycles after the accepting edge.
// Backpressure: req_ready is high only in IDLE; a request seen while busy waits.
//
// Ports:
//   clk_sys  : system clock, everything on the rising edge
//   reset_n  : asynchronous active-low reset; drives every pin to its idle level at once
//   bus      : gb_cart_bus_seq_if.slave (request, response and cartridge pins)
module gb_cart_bus_seq #(
    parameter int T_SETUP  = 4,   // address/data setup cycles before PHI rises (>=1)
    parameter int T_STROBE = 16,  // PHI-high / strobe cycles (>=2)
    parameter int T_HOLD   = 4    // address/data hold cycles after the strobe (>=1)
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    gb_cart_bus_seq_if.slave   bus
);

    localparam int T_MAX_SH = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
    localparam int CNT_MAX  = (T_STROBE > T_MAX_SH) ? T_STROBE : T_MAX_SH;
    localparam int CW       = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] LD_SETUP  = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_STROBE = CW'(T_STROBE - 1);
    localparam logic [CW-1:0] LD_HOLD   = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // FSM state and phase counter
    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    state_t          w_state_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_accept;
    logic            w_capture;

    // Request latch. The address and write data are latched straight into the
    // cart_a / cart_dq_out pin registers, which only load on acceptance, so only
    // the direction bit needs a register of its own.
    logic            r_wr;
    logic [7:0]      r_rdata_lat;

    // Registered outputs
    logic            r_req_ready;
    logic            r_rsp_valid;
    logic [7:0]      r_rsp_rdata;
    logic            r_phi;
    logic            r_rd_n;
    logic            r_wr_n;
    logic            r_cs_n;
    logic [15:0]     r_a;
    logic [7:0]      r_dq_out;
    logic            r_dq_dir;

    // Next values for the output registers
    logic            w_wr_eff;
    logic [15:0]     w_addr_eff;
    logic            w_busy_nxt;
    logic            w_cs_sel;
    logic            w_req_ready_nxt;
    logic            w_rsp_valid_nxt;
    logic [7:0]      w_rsp_rdata_nxt;
    logic            w_phi_nxt;
    logic            w_rd_n_nxt;
    logic            w_wr_n_nxt;
    logic            w_cs_n_nxt;
    logic [15:0]     w_a_nxt;
    logic [7:0]      w_dq_out_nxt;
    logic            w_dq_dir_nxt;

    //------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    //------------------------------------------------------------------
    // Next-state logic. Each timed state loads the counter with T_x-1 on
    // entry and leaves when the count reaches zero, so it lasts T_x cycles.
    //------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = LD_SETUP;
                    w_accept    = 1'b1;
                end
            end
            ST_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_STROBE;
                    w_cnt_nxt   = LD_STROBE;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end
            end
            ST_STROBE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = LD_HOLD;
                    // Last PHI-high cycle: the cart has had the whole strobe to
                    // settle its data, so this edge is the read sample point.
                    w_capture   = ~r_wr;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Pin next values. Outputs are registered from the *next* state so the
    // pins change on the same edge as the state and never glitch. On the
    // accepting edge the latches are still loading, so the incoming request
    // fields are used directly.
    //------------------------------------------------------------------
    always_comb begin
        w_wr_eff        = w_accept ? bus.req_wr   : r_wr;
        w_addr_eff      = w_accept ? bus.req_addr : r_a;
        w_busy_nxt      = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_STROBE) ||
                          (w_state_nxt == ST_HOLD);
        // Chip select only for the external RAM / camera window A000-BFFF.
        w_cs_sel        = (w_addr_eff[15:13] == 3'b101);

        w_req_ready_nxt = (w_state_nxt == ST_IDLE);
        w_rsp_valid_nxt = (w_state_nxt == ST_DONE);
        w_rsp_rdata_nxt = r_rsp_rdata;
        if (w_state_nxt == ST_DONE) begin
            w_rsp_rdata_nxt = r_wr ? 8'h00 : r_rdata_lat;
        end

        w_phi_nxt       = (w_state_nxt == ST_STROBE);
        // /RD covers setup, strobe and hold of a read; /WR only the PHI-high
        // window of a write, inside the window where the data bus is driven,
        // so the two strobes can never overlap.
        w_rd_n_nxt      = ~(w_busy_nxt && !w_wr_eff);
        w_wr_n_nxt      = ~((w_state_nxt == ST_STROBE) && w_wr_eff);
        w_cs_n_nxt      = ~((w_state_nxt == ST_STROBE) && w_cs_sel);
        w_dq_dir_nxt    = w_busy_nxt && w_wr_eff;

        // Address and write data load on acceptance and otherwise hold, which
        // keeps cart_a on the last address through DONE and IDLE.
        w_a_nxt         = w_addr_eff;
        w_dq_out_nxt    = r_dq_out;
        if (w_accept) begin
            w_dq_out_nxt = bus.req_wr ? bus.req_wdata : 8'h00;
        end
    end

    //------------------------------------------------------------------
    // Request and read-data latches
    //------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wr        <= 1'b0;
            r_rdata_lat <= 8'h00;
        end else begin
            if (w_accept) begin
                r_wr <= bus.req_wr;
            end
            if (w_capture) begin
                r_rdata_lat <= bus.cart_dq_in;
            end
        end
    end

    //------------------------------------------------------------------
    // Output registers; reset forces the pins idle immediately, so an
    // interrupted cycle simply vanishes and never reaches DONE.
    //------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'h00;
            r_phi       <= 1'b0;
            r_rd_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_cs_n      <= 1'b1;
            r_a         <= 16'h0000;
            r_dq_out    <= 8'h00;
            r_dq_dir    <= 1'b0;
        end else begin
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_phi       <= w_phi_nxt;
            r_rd_n      <= w_rd_n_nxt;
            r_wr_n      <= w_wr_n_nxt;
            r_cs_n      <= w_cs_n_nxt;
            r_a         <= w_a_nxt;
            r_dq_out    <= w_dq_out_nxt;
            r_dq_dir    <= w_dq_dir_nxt;
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.cart_phi    = r_phi;
    assign bus.cart_rd_n   = r_rd_n;
    assign bus.cart_wr_n   = r_wr_n;
    assign bus.cart_cs_n   = r_cs_n;
    assign bus.cart_a      = r_a;
    assign bus.cart_dq_out = r_dq_out;
    assign bus.cart_dq_dir = r_dq_dir;

endmodule

// File: tb/tb_gb_cart_bus_seq.sv
// Purpose : self-checking bench for gb_cart_bus_seq (default timing and 1/2/1 timing).
// Latency : checks the cycle count from acceptance to rsp_valid for every request.
// Backpressure: drives req_valid until accepted; also exercises held-valid back-to-back.
module tb_gb_cart_bus_seq;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset_n;
    logic        vld0, vld1, t_wr;
    logic [15:0] t_addr;
    logic [7:0]  t_wdata, t_dq;

    gb_cart_bus_seq_if bus0 ();
    gb_cart_bus_seq_if bus1 ();

    assign bus0.req_valid  = vld0;
    assign bus0.req_wr     = t_wr;
    assign bus0.req_addr   = t_addr;
    assign bus0.req_wdata  = t_wdata;
    assign bus0.cart_dq_in = t_dq;
    assign bus1.req_valid  = vld1;
    assign bus1.req_wr     = t_wr;
    assign bus1.req_addr   = t_addr;
    assign bus1.req_wdata  = t_wdata;
    assign bus1.cart_dq_in = t_dq;

    gb_cart_bus_seq dut0 (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    gb_cart_bus_seq #(.T_SETUP(1), .T_STROBE(2), .T_HOLD(1)) dut1 (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    // Observation mux: sel picks which DUT the checks look at.
    int          sel = 0;
    logic        o_ready, o_rsp, o_phi, o_rd_n, o_wr_n, o_cs_n, o_dir;
    logic [15:0] o_a;
    logic [7:0]  o_rdata, o_dq_out;
    always_comb begin
        o_ready  = (sel == 1) ? bus1.req_ready   : bus0.req_ready;
        o_rsp    = (sel == 1) ? bus1.rsp_valid   : bus0.rsp_valid;
        o_rdata  = (sel == 1) ? bus1.rsp_rdata   : bus0.rsp_rdata;
        o_phi    = (sel == 1) ? bus1.cart_phi    : bus0.cart_phi;
        o_rd_n   = (sel == 1) ? bus1.cart_rd_n   : bus0.cart_rd_n;
        o_wr_n   = (sel == 1) ? bus1.cart_wr_n   : bus0.cart_wr_n;
        o_cs_n   = (sel == 1) ? bus1.cart_cs_n   : bus0.cart_cs_n;
        o_a      = (sel == 1) ? bus1.cart_a      : bus0.cart_a;
        o_dq_out = (sel == 1) ? bus1.cart_dq_out : bus0.cart_dq_out;
        o_dir    = (sel == 1) ? bus1.cart_dq_dir : bus0.cart_dq_dir;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t required < 500000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample point: 1 unit after the falling edge, well away from the rising edge.
    task automatic step();
        @(negedge clk_sys);
        #1;
    endtask

    // Reference model: one request on DUT s with timing (ts, tstr, th).
    // Expected pin activity follows directly from the cycle description:
    // /RD low for the whole setup+strobe+hold of a read, /WR and PHI high for
    // the strobe, /CS only in A000-BFFF, data driven for the whole write, and
    // read data equal to what the cart presented on the last PHI-high cycle.
    task automatic run_txn(input int s, input logic wr, input logic [15:0] addr,
                           input logic [7:0] wdata, input logic [7:0] dq_target,
                           input int ts, input int tstr, input int th,
                           input bit hold_vld, input string tag,
                           output int acc_cyc, output int rsp_cyc);
        int  total, lat;
        int  rd_lo, wr_lo, phi_hi, cs_lo, dir_hi, rdy_hi;
        int  bad_wr, bad_ovl, bad_cs, bad_a, bad_dq;
        bit  seen_acc, seen_rsp;
        bit  in_window;
        total = ts + tstr + th;
        lat = 0; rd_lo = 0; wr_lo = 0; phi_hi = 0; cs_lo = 0; dir_hi = 0; rdy_hi = 0;
        bad_wr = 0; bad_ovl = 0; bad_cs = 0; bad_a = 0; bad_dq = 0;
        seen_acc = 0; seen_rsp = 0; acc_cyc = 0; rsp_cyc = 0;
        in_window = (addr >= 16'hA000) && (addr <= 16'hBFFF);

        step();
        sel = s; t_wr = wr; t_addr = addr; t_wdata = wdata;
        if (s == 1) vld1 = 1'b1; else vld0 = 1'b1;
        #1;
        check({tag, " rsp_valid low in idle"}, o_rsp, 1'b0);
        for (int i = 0; i < 100 && !seen_acc; i++) begin
            if (i > 0) step();
            if (o_ready) begin
                seen_acc = 1;
                acc_cyc  = cyc;
            end
        end
        check({tag, " accepted"}, seen_acc, 1'b1);

        for (int n = 1; n <= 200 && seen_acc && !seen_rsp; n++) begin
            step();
            if (n == 1 && !hold_vld) begin
                vld0 = 1'b0;
                vld1 = 1'b0;
            end
            if (!o_rd_n) rd_lo++;
            if (!o_wr_n) wr_lo++;
            if (o_phi)   phi_hi++;
            if (!o_cs_n) cs_lo++;
            if (o_dir)   dir_hi++;
            if (o_ready) rdy_hi++;
            if (!o_wr_n && (!o_dir || !o_phi)) bad_wr++;
            if (!o_rd_n && !o_wr_n) bad_ovl++;
            if (!o_cs_n && !o_phi) bad_cs++;
            if (o_a !== addr) bad_a++;
            if (o_dir && (o_dq_out !== wdata)) bad_dq++;
            if (o_phi && phi_hi == tstr) t_dq = dq_target;
            else                         t_dq = 8'($urandom);
            if (o_rsp) begin
                seen_rsp = 1;
                lat      = n;
                rsp_cyc  = cyc;
            end
        end

        check({tag, " rsp seen"},        seen_rsp, 1'b1);
        check({tag, " latency"},         lat, total + 1);
        check({tag, " rd_n low cycles"}, rd_lo, wr ? 0 : total);
        check({tag, " wr_n low cycles"}, wr_lo, wr ? tstr : 0);
        check({tag, " phi high cycles"}, phi_hi, tstr);
        check({tag, " cs_n low cycles"}, cs_lo, in_window ? tstr : 0);
        check({tag, " dq_dir cycles"},   dir_hi, wr ? total : 0);
        check({tag, " ready while busy"}, rdy_hi, 0);
        check({tag, " wr_n outside phi/dir"}, bad_wr, 0);
        check({tag, " rd_n wr_n overlap"}, bad_ovl, 0);
        check({tag, " cs_n outside phi"}, bad_cs, 0);
        check({tag, " cart_a held"},     bad_a, 0);
        check({tag, " dq_out value"},    bad_dq, 0);
        check({tag, " rsp_rdata"},       o_rdata, wr ? 8'h00 : dq_target);
    endtask

    task automatic check_idle_pins(input string tag);
        check({tag, " req_ready"},   o_ready, 1'b1);
        check({tag, " rsp_valid"},   o_rsp, 1'b0);
        check({tag, " rsp_rdata"},   o_rdata, 8'h00);
        check({tag, " cart_phi"},    o_phi, 1'b0);
        check({tag, " cart_rd_n"},   o_rd_n, 1'b1);
        check({tag, " cart_wr_n"},   o_wr_n, 1'b1);
        check({tag, " cart_cs_n"},   o_cs_n, 1'b1);
        check({tag, " cart_a"},      o_a, 16'h0000);
        check({tag, " cart_dq_out"}, o_dq_out, 8'h00);
        check({tag, " cart_dq_dir"}, o_dir, 1'b0);
    endtask

    initial begin
        int          a1, r1, a2, r2;
        int          cnt;
        bit          ok;
        logic        rwr;
        logic [15:0] raddr;
        logic [7:0]  rwd, rdq;

        reset_n = 1'b0;
        vld0 = 1'b0; vld1 = 1'b0;
        t_wr = 1'b0; t_addr = 16'h0000; t_wdata = 8'h00; t_dq = 8'h00;

        // Reset state of both instances
        step(); step();
        sel = 0; #1;
        check_idle_pins("reset dut0");
        sel = 1; #1;
        check_idle_pins("reset dut1");
        sel = 0;
        step();
        reset_n = 1'b1;
        step();

        // Directed requests
        run_txn(0, 1'b0, 16'h4123, 8'h00, 8'h5A, 4, 16, 4, 1'b0, "read 4123", a1, r1);
        run_txn(0, 1'b1, 16'h2000, 8'h03, 8'h00, 4, 16, 4, 1'b0, "write 2000", a1, r1);
        run_txn(0, 1'b0, 16'hA010, 8'h00, 8'h96, 4, 16, 4, 1'b0, "read A010", a1, r1);
        run_txn(0, 1'b1, 16'hBFFF, 8'hE7, 8'h00, 4, 16, 4, 1'b0, "write BFFF", a1, r1);
        run_txn(0, 1'b0, 16'hC000, 8'h00, 8'h11, 4, 16, 4, 1'b0, "read C000", a1, r1);

        // Back-to-back with req_valid held high
        run_txn(0, 1'b0, 16'h1234, 8'h00, 8'hC5, 4, 16, 4, 1'b1, "b2b first", a1, r1);
        run_txn(0, 1'b1, 16'hA055, 8'h7E, 8'h00, 4, 16, 4, 1'b0, "b2b second", a2, r2);
        check("b2b accept gap", a2 - r1, 1);

        // Reset pulse in the middle of a write strobe
        step();
        sel = 0; t_wr = 1'b1; t_addr = 16'hA123; t_wdata = 8'hC3; vld0 = 1'b1;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (i > 0) step();
            if (o_ready) ok = 1;
        end
        check("rst-mid accepted", ok, 1'b1);
        cnt = 0;
        for (int i = 0; i < 100 && cnt < 5; i++) begin
            step();
            vld0 = 1'b0;
            if (o_phi) cnt++;
        end
        check("rst-mid reached strobe", cnt, 5);
        check("rst-mid wr_n low before reset", o_wr_n, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle_pins("rst-mid");
        step();
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (o_rsp) cnt++;
        end
        check("rst-mid no response", cnt, 0);
        run_txn(0, 1'b0, 16'hA200, 8'h00, 8'h42, 4, 16, 4, 1'b0, "after reset", a1, r1);

        // Short timing instance
        run_txn(1, 1'b0, 16'h0150, 8'h00, 8'h3C, 1, 2, 1, 1'b0, "short read", a1, r1);
        run_txn(1, 1'b1, 16'hA7F0, 8'h99, 8'h00, 1, 2, 1, 1'b0, "short write", a1, r1);

        // Randomized requests against the model
        for (int k = 0; k < 18; k++) begin
            rwr = 1'($urandom);
            if ($urandom_range(0, 2) == 0) raddr = 16'hA000 | 16'($urandom_range(0, 16'h1FFF));
            else                           raddr = 16'($urandom);
            rwd = 8'($urandom);
            rdq = 8'($urandom);
            if (k < 12)
                run_txn(0, rwr, raddr, rwd, rdq, 4, 16, 4, 1'b0, "random dut0", a1, r1);
            else
                run_txn(1, rwr, raddr, rwd, rdq, 1, 2, 1, 1'b0, "random dut1", a1, r1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
